spi_slave: RTL
==============

# spi_slave

Synthesizable SPI slave frame interface that sits directly downstream of the behavioral SPI master model on the cs_b/sclk/mosi/miso bus. It deserializes one 64-bit frame per cs_b assertion: 7 payload bytes plus a CRC-8 byte. In the same transaction it serializes a 7-byte response frame plus its CRC on miso. On the system side it presents the received payload with a single-cycle valid pulse and CRC/abort status.

## Interface
- CLK_PER_BIT_MIN, 8, minimum clk cycles per SPI bit (documentation/assertion bound only)
- FRAME_BYTES, 8, bytes per frame including CRC (fixed; not to be overridden)
- clk  input  1  system clock; all logic on rising edge
- rst_b  input  1  asynchronous active-low reset, synchronous deassertion handled externally
- cs_b  input  1  SPI chip select, active low, asynchronous to clk
- sclk  input  1  SPI clock, idle low, asynchronous to clk
- mosi  input  1  master-out data, MSB first
- miso  output  1  slave-out data, MSB first
- tx_data  input  56  response payload; byte 6 = [55:48] sent first
- rx_data  output  56  received payload; first received byte in [55:48]
- rx_valid  output  1  one-cycle pulse, complete 64-bit frame received
- rx_crc_err  output  1  CRC status of the last completed frame, held until next frame completes
- frame_abort  output  1  one-cycle pulse, cs_b deasserted before 64 bits

## Operation
- cs_b, sclk and mosi each pass through a 2-flop synchronizer. Edges are detected on the synchronized values with one extra history flop.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on synchronized cs_b falling edge: clear bit counter (7 bits); load tx shift register with tx_data; seed tx and rx CRC with 0xFF; drive miso = tx_data[55].
  - SHIFT, on sclk rising edge: shift synchronized mosi into rx shift register and increment bit counter. For bits 0..55, update rx CRC with that bit.
  - SHIFT, on sclk falling edge: advance miso to the next bit. Bits 56..63 come from the tx CRC register, MSB first.
  - SHIFT -> DONE when counter reaches 64. rx_data <= first 56 bits. rx_crc_err <= (rx CRC after also absorbing the 8 received CRC bits != 0). rx_valid pulses.
  - SHIFT -> IDLE on cs_b rising edge with counter < 64: frame_abort pulses; rx_data and rx_crc_err unchanged.
  - DONE -> IDLE on cs_b rising edge. Extra sclk edges in DONE are ignored and miso = 0.
- CRC: CRC-8, polynomial 0x2F, seed 0xFF, MSB-first, no reflection, no final XOR. It is computed bitwise, one bit per sclk edge. The tx CRC covers the 7 tx bytes, so the master's residue check over all 8 bytes yields 0.
- miso = 0 in IDLE.
- tx_data is sampled only at the frame-start edge. Later changes have no effect on the current frame.

## Timing
- Reset values: miso 0, rx_data 0, rx_valid 0, rx_crc_err 0, frame_abort 0, FSM IDLE.
- Reset mid-frame: immediate return to IDLE with no pulses. A frame already in progress is not recovered; the next cs_b falling edge starts a new frame.
- Clock ratio:
  - clk period ≤ SPI bit period / CLK_PER_BIT_MIN, with sclk high and low phases each ≥ 4 clk.
  - At the 10 Mbps default, clk ≥ 80 MHz.
- Edge detection latency is 3 clk after the pin edge, so miso changes 3–4 clk after the sclk falling edge (or cs_b falling edge for the first bit). That is within half a bit period at ratio ≥ 8.
- rx_valid asserts 4 clk after the 64th sclk rising edge at the pin. frame_abort asserts 4 clk after the cs_b rising edge.
- Simultaneous sclk edge and cs_b rise in the same clk: cs_b wins, the bit is discarded.

## Configuration
- SPI_SLAVE_CRC_EN defined:
  - CRC generation and checking as described.
- SPI_SLAVE_CRC_EN undefined:
  - CRC registers are removed.
  - Bits 56..63 on miso are 0x00.
  - Received bits 56..63 are shifted in but ignored.
  - rx_crc_err is tied 0.

## Structure
- Package spi_pkg holds:
  - CRC_POLY = 8'h2F, CRC_SEED = 8'hFF, CRC_WIDTH = 8, FRAME_BITS = 64, PAYLOAD_BITS = 56.
  - FSM state typedef (IDLE, SHIFT, DONE).
  - Single-bit CRC update function.
- Sub-module spi_sync: 2-flop synchronizer with async active-low reset, reset value parameterized. There are three instances: cs_b resets to 1, sclk to 0, mosi to 0.

## Test plan
- Master sends payload 0x01_02_03_04_05_06_07 with valid CRC -> rx_valid one pulse, rx_data = 0x01020304050607, rx_crc_err = 0.
- Same frame with CRC byte XORed by 0x01 -> rx_valid pulse, rx_crc_err = 1, held until the next good frame clears it.
- tx_data = 0xA5A5A5A5A5A5A5 loaded before cs_b falls -> master sees 0xA5 ×7 on miso, master rx_crc_error = 0; tx_data changed mid-frame does not alter miso.
- cs_b released after 20 bits -> frame_abort one pulse, no rx_valid, rx_data retains the previous value; next full frame is received correctly.
- rst_b asserted after 30 bits -> all outputs 0 immediately; after release, a full frame yields rx_valid with correct data.
- 72 sclk pulses in one cs_b window -> exactly one rx_valid after bit 64, miso = 0 for bits 65–72.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants, FSM state type and bitwise CRC-8 helper for the SPI slave.
package spi_pkg;

    localparam int unsigned CRC_WIDTH    = 8;
    localparam int unsigned FRAME_BITS   = 64;
    localparam int unsigned PAYLOAD_BITS = 56;

    localparam logic [CRC_WIDTH-1:0] CRC_POLY = 8'h2F;
    localparam logic [CRC_WIDTH-1:0] CRC_SEED = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // One MSB-first CRC step, no reflection.
    function automatic logic [CRC_WIDTH-1:0] crc8_bit(input logic [CRC_WIDTH-1:0] crc,
                                                      input logic                 din);
        logic fb;
        fb = crc[CRC_WIDTH-1] ^ din;
        return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a parameterized reset value.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave frame interface: 56-bit payload + CRC-8 in, 56-bit response + CRC-8 out.
// CRC generation/checking is built only when SPI_SLAVE_CRC_EN is defined.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT_MIN = 8,
    parameter int unsigned FRAME_BYTES     = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cs_b,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    input  logic [55:0] tx_data,
    output logic [55:0] rx_data,
    output logic        rx_valid,
    output logic        rx_crc_err,
    output logic        frame_abort
);

    if (FRAME_BYTES * 8 != FRAME_BITS) begin : g_bad_frame
        $error("spi_slave: FRAME_BYTES must be 8");
    end
    if (CLK_PER_BIT_MIN < 8) begin : g_bad_ratio
        $error("spi_slave: CLK_PER_BIT_MIN must be at least 8");
    end

    logic cs_s, sclk_s, mosi_s;
    logic cs_hist_q, sclk_hist_q;

    spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_b(rst_b), .d_i(cs_b), .q_o(cs_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_b(rst_b), .d_i(sclk), .q_o(sclk_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_b(rst_b), .d_i(mosi), .q_o(mosi_s));

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    assign cs_fall   = cs_hist_q & ~cs_s;
    assign cs_rise   = ~cs_hist_q & cs_s;
    assign sclk_rise = ~sclk_hist_q & sclk_s;
    assign sclk_fall = sclk_hist_q & ~sclk_s;

    state_e      state_q;
    logic [6:0]  bit_cnt_q;
    logic [62:0] rx_sr_q;
    logic [54:0] tx_sr_q;
    logic        miso_q;
    logic [55:0] rx_data_q;
    logic        rx_valid_q;
    logic        frame_abort_q;

`ifdef SPI_SLAVE_CRC_EN
    logic [CRC_WIDTH-1:0] rx_crc_q;
    logic [CRC_WIDTH-1:0] tx_crc_q;
    logic [CRC_WIDTH-1:0] tx_crc_step;
    logic                 rx_crc_err_q;

    // miso_q holds the payload bit currently on the wire, which is what the tx CRC absorbs
    assign tx_crc_step = crc8_bit(tx_crc_q, miso_q);
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cs_hist_q     <= 1'b1;
            sclk_hist_q   <= 1'b0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_sr_q       <= '0;
            tx_sr_q       <= '0;
            miso_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_abort_q <= 1'b0;
`ifdef SPI_SLAVE_CRC_EN
            rx_crc_q      <= CRC_SEED;
            tx_crc_q      <= CRC_SEED;
            rx_crc_err_q  <= 1'b0;
`endif
        end else begin
            cs_hist_q     <= cs_s;
            sclk_hist_q   <= sclk_s;
            rx_valid_q    <= 1'b0;
            frame_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        tx_sr_q   <= tx_data[54:0];
                        miso_q    <= tx_data[55];
`ifdef SPI_SLAVE_CRC_EN
                        rx_crc_q  <= CRC_SEED;
                        tx_crc_q  <= CRC_SEED;
`endif
                    end
                end
                SHIFT: begin
                    // cs_b release takes priority over a coincident sclk edge
                    if (cs_rise) begin
                        state_q       <= IDLE;
                        miso_q        <= 1'b0;
                        frame_abort_q <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_sr_q   <= {rx_sr_q[61:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + 7'd1;
`ifdef SPI_SLAVE_CRC_EN
                        rx_crc_q  <= crc8_bit(rx_crc_q, mosi_s);
`endif
                        if (bit_cnt_q == 7'(FRAME_BITS - 1)) begin
                            state_q    <= DONE;
                            miso_q     <= 1'b0;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sr_q[62:7];
`ifdef SPI_SLAVE_CRC_EN
                            rx_crc_err_q <= (crc8_bit(rx_crc_q, mosi_s) != '0);
`endif
                        end
                    end else if (sclk_fall && (bit_cnt_q != '0)) begin
                        tx_sr_q <= {tx_sr_q[53:0], 1'b0};
`ifdef SPI_SLAVE_CRC_EN
                        if (bit_cnt_q < 7'(PAYLOAD_BITS)) begin
                            miso_q   <= tx_sr_q[54];
                            tx_crc_q <= tx_crc_step;
                        end else if (bit_cnt_q == 7'(PAYLOAD_BITS)) begin
                            miso_q   <= tx_crc_step[CRC_WIDTH-1];
                            tx_crc_q <= {tx_crc_step[CRC_WIDTH-2:0], 1'b0};
                        end else begin
                            miso_q   <= tx_crc_q[CRC_WIDTH-1];
                            tx_crc_q <= {tx_crc_q[CRC_WIDTH-2:0], 1'b0};
                        end
`else
                        // the drained shift register supplies zeros for the CRC slot
                        miso_q <= tx_sr_q[54];
`endif
                    end
                end
                DONE: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso        = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_abort = frame_abort_q;
`ifdef SPI_SLAVE_CRC_EN
    assign rx_crc_err  = rx_crc_err_q;
`else
    assign rx_crc_err  = 1'b0;
`endif

endmodule
